// File: rtl/working_mem_arbiter.sv
// Working-memory arbiter: grants one of N_MASTERS requesters access to a
// shared synchronous RAM. The owner's address, data and write enable are
// steered to the memory, and read data is flagged one cycle later.
// Arbitration is fixed priority or round-robin, with an optional hold limit
// that forces the owner to release while another master is waiting.
module working_mem_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int RR_MODE   = 0,
  parameter int MAX_HOLD  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  input  logic [N_MASTERS-1:0]          m_wren,
  output logic [N_MASTERS-1:0]          grant,
  output logic [N_MASTERS-1:0]          rd_valid,
  output logic                          busy,
  output logic [2:0]                    owner_id,
  output logic [ADDR_W-1:0]             out_address,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_wren
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [N_MASTERS-1:0]   rd_valid_q, rd_valid_d;
  logic [2:0]             owner_q, owner_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  logic [7:0]             cand_s;
  logic [7:0]             onehot_s;
  logic [2:0]             start_s;
  logic [2:0]             idx_s;
  logic [2:0]             win_idx_s;
  logic                   win_found_s;
  logic                   owner_req_s;
  logic                   others_wait_s;
  logic                   forced_s;

  // Candidate set excludes the current owner; in IDLE grant_q is zero so
  // every requester is a candidate. The hold counter holds the number of
  // already-completed owned cycles, so the owner is released at the end of
  // its MAX_HOLD-th cycle when someone else is waiting.
  always_comb begin
    cand_s                 = 8'd0;
    cand_s[N_MASTERS-1:0]  = req & ~grant_q;
    owner_req_s            = |(req & grant_q);
    others_wait_s          = |(req & ~grant_q);
    forced_s               = (MAX_HOLD > 0) && (int'(hold_q) >= MAX_HOLD - 1) && others_wait_s;
  end

  // Winner search: upward with wrap-around from the start index
  // (always 0 for fixed priority, last owner + 1 for round-robin).
  always_comb begin
    start_s     = (RR_MODE != 0) ? rr_ptr_q : 3'd0;
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    idx_s       = 3'd0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx_s = 3'((int'(start_s) + k) % N_MASTERS);
      if (!win_found_s && cand_s[idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    onehot_s = 8'd1 << win_idx_s;
  end

  // Next-state logic for ownership, round-robin pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    rd_valid_d = grant_q & req & ~m_wren;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d  = OWNED;
          grant_d  = onehot_s[N_MASTERS-1:0];
          owner_d  = win_idx_s;
          rr_ptr_d = 3'((int'(win_idx_s) + 1) % N_MASTERS);
          hold_d   = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      OWNED: begin
        if (owner_req_s && !forced_s) begin
          if (int'(hold_q) < MAX_HOLD) begin
            hold_d = hold_q + HOLD_W'(1);
          end else begin
            hold_d = hold_q;
          end
        end else if (win_found_s) begin
          grant_d  = onehot_s[N_MASTERS-1:0];
          owner_d  = win_idx_s;
          rr_ptr_d = 3'((int'(win_idx_s) + 1) % N_MASTERS);
          hold_d   = '0;
        end else begin
          state_d  = IDLE;
          grant_d  = '0;
          owner_d  = 3'd0;
          hold_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = 3'd0;
        hold_d  = '0;
      end
    endcase
  end

  // State registers; asynchronous reset clears ownership immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rd_valid_q <= '0;
      owner_q    <= 3'd0;
      rr_ptr_q   <= 3'd0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rd_valid_q <= rd_valid_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
    end
  end

  // Memory-side steering: AND-OR mux on the one-hot grant, zero with no owner.
  always_comb begin
    out_address = '0;
    out_data    = '0;
    out_wren    = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      out_address = out_address | (m_address[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[i]}});
      out_data    = out_data    | (m_data[i*DATA_W +: DATA_W]    & {DATA_W{grant_q[i]}});
      out_wren    = out_wren    | (grant_q[i] & m_wren[i] & req[i]);
    end
  end

  assign grant    = grant_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == OWNED);
  assign owner_id = owner_q;

endmodule

// File: tb/tb_working_mem_arbiter.sv
// Directed bench for working_mem_arbiter: three instances (fixed priority,
// round-robin, fixed priority with MAX_HOLD=4) share one stimulus stream.
module tb_working_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] m_address;
  logic [23:0] m_data;
  logic [2:0]  m_wren;

  logic [2:0] fp_grant, fp_rdv, fp_owner;
  logic       fp_busy, fp_wren;
  logic [7:0] fp_addr, fp_data;
  logic [2:0] rr_grant, rr_rdv, rr_owner;
  logic       rr_busy, rr_wren;
  logic [7:0] rr_addr, rr_data;
  logic [2:0] mh_grant, mh_rdv, mh_owner;
  logic       mh_busy, mh_wren;
  logic [7:0] mh_addr, mh_data;

  int total = 0;
  int bad   = 0;

  working_mem_arbiter #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(8), .RR_MODE(0), .MAX_HOLD(0)) u_fp (
    .clk(clk), .reset(reset), .req(req), .m_address(m_address), .m_data(m_data), .m_wren(m_wren),
    .grant(fp_grant), .rd_valid(fp_rdv), .busy(fp_busy), .owner_id(fp_owner),
    .out_address(fp_addr), .out_data(fp_data), .out_wren(fp_wren));

  working_mem_arbiter #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(8), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .reset(reset), .req(req), .m_address(m_address), .m_data(m_data), .m_wren(m_wren),
    .grant(rr_grant), .rd_valid(rr_rdv), .busy(rr_busy), .owner_id(rr_owner),
    .out_address(rr_addr), .out_data(rr_data), .out_wren(rr_wren));

  working_mem_arbiter #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(8), .RR_MODE(0), .MAX_HOLD(4)) u_mh (
    .clk(clk), .reset(reset), .req(req), .m_address(m_address), .m_data(m_data), .m_wren(m_wren),
    .grant(mh_grant), .rd_valid(mh_rdv), .busy(mh_busy), .owner_id(mh_owner),
    .out_address(mh_addr), .out_data(mh_data), .out_wren(mh_wren));

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = 3'b000;
    m_wren = 3'b000;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 3'b000;
    m_wren    = 3'b000;
    m_address = {8'h2C, 8'h3A, 8'h11};
    m_data    = {8'h5A, 8'h22, 8'h33};
    #1;
    check_eq("rst_fp", {5'd0, fp_grant, fp_rdv, fp_busy, fp_owner, fp_wren, fp_addr, fp_data}, 32'd0);
    check_eq("rst_rr", {5'd0, rr_grant, rr_rdv, rr_busy, rr_owner, rr_wren, rr_addr, rr_data}, 32'd0);
    check_eq("rst_mh", {5'd0, mh_grant, mh_rdv, mh_busy, mh_owner, mh_wren, mh_addr, mh_data}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    tick();
    check_eq("idle_no_req", {29'd0, fp_grant}, {29'd0, 3'b000});

    // Fixed priority from IDLE, then a read by master 1 and handoff to 2.
    req = 3'b110;
    #1;
    check_eq("pre_edge_grant", {29'd0, fp_grant}, {29'd0, 3'b000});
    tick();
    check_eq("fp_grant1", {29'd0, fp_grant}, {29'd0, 3'b010});
    check_eq("fp_owner1", {29'd0, fp_owner}, 32'd1);
    check_eq("fp_busy1", {31'd0, fp_busy}, 32'd1);
    check_eq("rd_addr", {24'd0, fp_addr}, 32'h3A);
    check_eq("rd_wren", {31'd0, fp_wren}, 32'd0);
    check_eq("rdv_early", {29'd0, fp_rdv}, {29'd0, 3'b000});
    tick();
    check_eq("rdv_pulse", {29'd0, fp_rdv}, {29'd0, 3'b010});
    check_eq("fp_hold1", {29'd0, fp_grant}, {29'd0, 3'b010});
    req = 3'b100;
    #1;
    tick();
    check_eq("handoff", {29'd0, fp_grant}, {29'd0, 3'b100});
    check_eq("rdv_end", {29'd0, fp_rdv}, {29'd0, 3'b000});
    check_eq("fp_owner2", {29'd0, fp_owner}, 32'd2);
    check_eq("fp_addr2", {24'd0, fp_addr}, 32'h2C);

    // Master 2 writes, then reset is asserted between edges.
    m_wren = 3'b100;
    #1;
    check_eq("wr_wren", {31'd0, fp_wren}, 32'd1);
    check_eq("wr_data", {24'd0, fp_data}, 32'h5A);
    reset = 1'b1;
    #1;
    check_eq("async_grant", {29'd0, fp_grant}, {29'd0, 3'b000});
    check_eq("async_wren", {31'd0, fp_wren}, 32'd0);
    check_eq("async_busy", {31'd0, fp_busy}, 32'd0);
    check_eq("async_addr", {24'd0, fp_addr}, 32'd0);
    req    = 3'b000;
    m_wren = 3'b000;
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_busy", {31'd0, fp_busy}, 32'd0);
    check_eq("post_rst_grant", {29'd0, fp_grant}, {29'd0, 3'b000});

    // Rotation: round-robin visits 0,1,2,0; fixed priority returns to 0.
    req = 3'b111;
    tick();
    check_eq("rr_g0", {29'd0, rr_grant}, {29'd0, 3'b001});
    check_eq("fp_g0", {29'd0, fp_grant}, {29'd0, 3'b001});
    req = 3'b110;
    tick();
    check_eq("rr_g1", {29'd0, rr_grant}, {29'd0, 3'b010});
    check_eq("fp_g1", {29'd0, fp_grant}, {29'd0, 3'b010});
    req = 3'b101;
    tick();
    check_eq("rr_g2", {29'd0, rr_grant}, {29'd0, 3'b100});
    check_eq("fp_g2", {29'd0, fp_grant}, {29'd0, 3'b001});
    req = 3'b011;
    tick();
    check_eq("rr_g3", {29'd0, rr_grant}, {29'd0, 3'b001});
    check_eq("fp_g3", {29'd0, fp_grant}, {29'd0, 3'b001});
    req = 3'b000;
    tick();
    check_eq("idle_grant", {29'd0, fp_grant}, {29'd0, 3'b000});
    check_eq("idle_busy", {31'd0, fp_busy}, 32'd0);
    check_eq("idle_owner", {29'd0, rr_owner}, 32'd0);

    // Hold limit: master 0 keeps grant 4 cycles while master 2 waits.
    do_reset();
    req = 3'b101;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("mh_keep", {29'd0, mh_grant}, {29'd0, 3'b001});
    end
    tick();
    check_eq("mh_forced", {29'd0, mh_grant}, {29'd0, 3'b100});
    check_eq("mh_owner", {29'd0, mh_owner}, 32'd2);
    check_eq("mh_busy", {31'd0, mh_busy}, 32'd1);
    check_eq("fp_unlimited", {29'd0, fp_grant}, {29'd0, 3'b001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/working_mem_arbiter.md
WORKING_MEM_ARBITER -- requirements
Module: working_mem_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 3: number of requesting masters; legal range 2..8.
REQ-002 Parameter ADDR_W, default 8: memory address width.
REQ-003 Parameter DATA_W, default 8: memory data width.
REQ-004 Parameter RR_MODE, default 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
REQ-005 Parameter MAX_HOLD, default 0: maximum consecutive owned cycles before forced release while another master waits; 0 = unlimited.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 req  input  N_MASTERS  per-master access request; held high for as long as the master needs the memory.
REQ-009 m_address  input  N_MASTERS*ADDR_W  packed per-master addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 m_data  input  N_MASTERS*DATA_W  packed per-master write data.
REQ-011 m_wren  input  N_MASTERS  per-master write enables.
REQ-012 grant  output  N_MASTERS  one-hot-or-zero ownership, registered.
REQ-013 rd_valid  output  N_MASTERS  one-cycle pulse: memory read data for master i is valid this cycle.
REQ-014 busy  output  1  high while any master owns the memory.
REQ-015 owner_id  output  3  index of current owner; 0 when busy is low.
REQ-016 out_address  output  ADDR_W  address to working memory.
REQ-017 out_data  output  DATA_W  write data to working memory.
REQ-018 out_wren  output  1  write enable to working memory.

Function
REQ-019 The state machine SHALL have two states: IDLE (no owner) and OWNED (exactly one grant bit high).
REQ-020 In IDLE with any req high, the block SHALL select a winner and assert its grant on the next edge; IDLE with req all-zero SHALL stay IDLE.
REQ-021 In OWNED with the owner's req high and no forced release, grant SHALL remain unchanged.
REQ-022 In OWNED with the owner's req low, the block SHALL re-arbitrate among the remaining requesters in that same cycle, with no idle bubble; if none requests, it SHALL return to IDLE.
REQ-023 Fixed-priority winner SHALL be the lowest-index requester.
REQ-024 Round-robin winner SHALL be the first requester found searching upward, with wrap-around, starting at last owner + 1; after reset the search start SHALL be index 0.
REQ-025 With MAX_HOLD > 0, a hold counter SHALL count consecutive owned cycles, saturating at MAX_HOLD.
REQ-026 When the hold counter reaches MAX_HOLD and any other req is high, the owner SHALL be excluded from that cycle's arbitration and lose grant on the next edge; the counter SHALL clear on every grant change.
REQ-027 out_address, out_data and out_wren SHALL be combinational selections of the owner's inputs.
REQ-028 out_wren SHALL equal owner m_wren AND owner req; when there is no owner, out_wren SHALL be 0.
REQ-029 With no owner, out_address and out_data SHALL be 0.
REQ-030 rd_valid[i] SHALL be a registered copy of (grant[i] AND req[i] AND NOT m_wren[i]), giving 1-cycle read latency that matches the synchronous RAM.
REQ-031 grant SHALL never have more than one bit set, and SHALL never be set for a master whose req was low at the deciding edge.

Reset
REQ-032 While reset is high: grant = 0, rd_valid = 0, busy = 0, owner_id = 0, hold counter = 0, round-robin pointer = 0, state = IDLE, out_wren = 0.
REQ-033 Reset asserted mid-ownership SHALL drop grant and out_wren immediately, without waiting for a clock edge.
REQ-034 After reset is released, the first grant SHALL appear no earlier than the first rising edge at which req is sampled.

Verification
REQ-035 Fixed priority, N=3: req=3'b110 from IDLE -> grant=3'b010 one edge later; owner_id=1; busy=1.
REQ-036 Handoff: owner 1 drops req while req[2]=1 -> grant=3'b100 on the next edge, with no cycle of grant=0.
REQ-037 Round-robin: req=3'b111 held, each owner drops req for one cycle after one access -> grants rotate 0,1,2,0.
REQ-038 MAX_HOLD=4: master 0 holds req and master 2 requests -> master 0 keeps grant for 4 cycles, then grant=3'b100.
REQ-039 Read: owner 1 with address 8'h3A and m_wren=0 -> out_address=8'h3A the same cycle; rd_valid=3'b010 for exactly one cycle on the next edge.
REQ-040 Reset asserted while master 2 is writing (out_wren=1) -> grant=0 and out_wren=0 before the next edge; IDLE after reset is released.
